// File: rtl/request_link_pkg.sv
// Shared definitions for the serial request link.
// Holds the two legal line symbols, the fixed frame header, the frame-length
// helper and the receiver FSM state type.
package request_link_pkg;

    localparam logic [1:0] SYM_ONE  = 2'b01;
    localparam logic [1:0] SYM_ZERO = 2'b10;

    localparam int unsigned         HEADER_W    = 4;
    localparam logic [HEADER_W-1:0] HEADER_BITS = 4'b1101;

    // Header, payload and a single trailer bit.
    function automatic int unsigned frame_len(input int unsigned data_w);
        return HEADER_W + data_w + 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        RX   = 1'b1
    } rx_state_e;

endpackage

// File: rtl/request_readin_line_sync.sv
// Multi-flop synchronizer for the 2-bit request line.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   line          : raw serial line from the other clock domain
//   sym           : synchronized symbol
//   sym_changed_c : high while sym differs from the previous cycle's sym
// All flops, including the previous-symbol register, reset to SYM_ONE so a line
// already idling at 01 out of reset does not look like a transition.
module line_sync
    import request_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] line,
    output logic [1:0] sym,
    output logic       sym_changed_c
);

    logic [1:0] stages [SYNC_STAGES];
    logic [1:0] prev;

    // Synchronizer chain plus one-cycle history of the synchronized symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stages[i] <= SYM_ONE;
            end
            prev <= SYM_ONE;
        end else begin
            stages[0] <= line;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
            prev <= stages[SYNC_STAGES-1];
        end
    end

    assign sym           = stages[SYNC_STAGES-1];
    assign sym_changed_c = (stages[SYNC_STAGES-1] != prev);

endmodule

// File: rtl/request_readin.sv
// Receive-side decoder for the 2-bit serial request line.
// Recovers one DATA_W-bit request per frame (HEADER, payload, trailer 0, all
// MSB first, BIT_CYCLES clocks per bit), checks framing and reports the result.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   UserInput   : serial line, 01 = bit 1, 10 = bit 0, 00/11 illegal in a frame
//   Request     : last successfully decoded payload, held between frames
//   Request_vld : one-cycle pulse when Request has been updated
//   Frame_err   : one-cycle pulse when a frame is aborted
//   Busy        : high while a frame is being received
module request_readin
    import request_link_pkg::*;
#(
    parameter int unsigned         BIT_CYCLES  = 25,
    parameter int unsigned         DATA_W      = 12,
    parameter logic [HEADER_W-1:0] HEADER      = HEADER_BITS,
    parameter int unsigned         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        UserInput,
    output logic [DATA_W-1:0] Request,
    output logic              Request_vld,
    output logic              Frame_err,
    output logic              Busy
);

    localparam int unsigned FRAME_LEN = frame_len(DATA_W);
    localparam int unsigned CNT_W     = $clog2(BIT_CYCLES);
    localparam int unsigned BIT_W     = $clog2(FRAME_LEN);
    localparam int unsigned SAMPLE_PT = BIT_CYCLES / 2;

    logic [1:0]           sym;
    logic                 sym_changed_c;
    rx_state_e            state;
    logic [CNT_W-1:0]     cyc_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [FRAME_LEN-2:0] shreg;
    logic [FRAME_LEN-1:0] frame_c;
    logic                 sym_legal_c;
    logic                 frame_ok_c;
    logic                 last_bit_c;

    line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .line          (UserInput),
        .sym           (sym),
        .sym_changed_c (sym_changed_c)
    );

    // Frame as it would look once the current symbol is shifted in.
    assign frame_c     = {shreg, (sym == SYM_ONE)};
    assign sym_legal_c = (sym == SYM_ONE) || (sym == SYM_ZERO);
    assign frame_ok_c  = (frame_c[FRAME_LEN-1 -: HEADER_W] == HEADER) && !frame_c[0];
    assign last_bit_c  = (bit_cnt == BIT_W'(FRAME_LEN - 1));

    // Receiver FSM with bit timing, resync and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            Request     <= '0;
            Request_vld <= 1'b0;
            Frame_err   <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            Request_vld <= 1'b0;
            Frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sym_changed_c && (sym == SYM_ONE)) begin
                        state   <= RX;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        Busy    <= 1'b1;
                    end
                end
                RX: begin
                    if (sym_changed_c) begin
                        // A transition marks a bit boundary. If the counter has
                        // already wrapped (still before the sample point) the bit
                        // counter has advanced; otherwise the bit ended early.
                        cyc_cnt <= '0;
                        if (cyc_cnt > CNT_W'(SAMPLE_PT)) begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else if (cyc_cnt == CNT_W'(SAMPLE_PT)) begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                        if (!sym_legal_c) begin
                            Frame_err <= 1'b1;
                            state     <= IDLE;
                            Busy      <= 1'b0;
                        end else if (last_bit_c) begin
                            if (frame_ok_c) begin
                                Request     <= frame_c[DATA_W:1];
                                Request_vld <= 1'b1;
                            end else begin
                                Frame_err <= 1'b1;
                            end
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            shreg <= frame_c[FRAME_LEN-2:0];
                        end
                    end else if (cyc_cnt == CNT_W'(BIT_CYCLES - 1)) begin
                        cyc_cnt <= '0;
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_request_readin.sv
// Scoreboard bench for request_readin: stimulus pushes expected pulses, a
// negedge monitor pops and compares them whenever Request_vld or Frame_err fires.
module tb_request_readin;

    localparam int BC   = 25;
    localparam int SYNC = 2;
    localparam int FL   = 17;
    // Cycles from the first clock edge that samples a new symbol to the pulse.
    localparam int LAT     = SYNC + (FL - 1) * BC + BC / 2 + 1;
    localparam int ERR_LAT = SYNC + BC / 2 + 1;

    logic        clk;
    logic        rst_n;
    logic [1:0]  line;
    logic [11:0] request;
    logic        request_vld;
    logic        frame_err;
    logic        busy;

    request_readin #(
        .BIT_CYCLES  (25),
        .DATA_W      (12),
        .HEADER      (4'b1101),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .UserInput   (line),
        .Request     (request),
        .Request_vld (request_vld),
        .Frame_err   (frame_err),
        .Busy        (busy)
    );

    typedef struct {
        bit          is_err;
        logic [11:0] value;
        int          cycle;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    logic [11:0] model_req = '0;
    logic [3:0]  r_hdr;
    logic        r_tr;
    int          r_mode;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (request_vld || frame_err)) begin
            check("vld_err_exclusive", int'(request_vld && frame_err), 0);
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("pulse_is_err", int'(frame_err), int'(mon_e.is_err));
                check("request_value", int'(request), int'(mon_e.value));
                if (mon_e.cycle >= 0) check("pulse_cycle", cyc, mon_e.cycle);
            end
        end
    end

    task automatic gap(input int n);
        @(posedge clk); #1;
        check("busy_idle_between_frames", int'(busy), 0);
        line = 2'b10;
        repeat (n - 1) @(posedge clk);
    endtask

    // Sends one frame; bad_bit drives 11 for 30 cycles at that bit, rst_bit
    // pulses reset during that bit with the line parked at 01.
    task automatic send_frame(input logic [3:0] hdr, input logic [11:0] pl,
                              input logic tr, input int bitc,
                              input int bad_bit, input int rst_bit);
        logic [16:0] f;
        exp_t        e;
        f = {hdr, pl, tr};
        for (int i = 0; i < FL; i++) begin
            @(posedge clk); #1;
            if (i == 8) check("busy_in_frame", int'(busy), 1);
            if (i == rst_bit) begin
                line = 2'b01;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (5) @(posedge clk);
                #1 rst_n = 1'b1;
                model_req = '0;
                repeat (60) @(posedge clk);
                #1;
                check("request_after_reset", int'(request), 0);
                check("busy_after_reset", int'(busy), 0);
                return;
            end
            if (i == bad_bit) begin
                line     = 2'b11;
                e.is_err = 1'b1;
                e.value  = model_req;
                e.cycle  = cyc + 1 + ERR_LAT;
                exp_q.push_back(e);
                repeat (29) @(posedge clk);
                return;
            end
            line = f[16-i] ? 2'b01 : 2'b10;
            if (i == 0 && bad_bit < 0 && rst_bit < 0) begin
                e.is_err = !((hdr == 4'b1101) && (tr == 1'b0));
                if (!e.is_err) model_req = pl;
                e.value = model_req;
                e.cycle = (bitc == BC) ? cyc + 1 + LAT : -1;
                exp_q.push_back(e);
            end
            repeat (bitc - 1) @(posedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        line  = 2'b10;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_request", int'(request), 0);
        check("reset_vld", int'(request_vld), 0);
        check("reset_err", int'(frame_err), 0);
        check("reset_busy", int'(busy), 0);
        gap(20);

        // Nominal frame.
        send_frame(4'b1101, 12'hA5C, 1'b0, BC, -1, -1);
        gap(20);

        // Back-to-back, second frame has a 13-bit run of ones.
        send_frame(4'b1101, 12'h000, 1'b0, BC, -1, -1);
        send_frame(4'b1101, 12'hFFF, 1'b0, BC, -1, -1);
        gap(20);

        // Illegal symbol on payload bit 5 (frame bit 9).
        send_frame(4'b1101, 12'h6B2, 1'b0, BC, 9, -1);
        gap(40);

        // Bad header, then bad trailer.
        send_frame(4'b1001, 12'h123, 1'b0, BC, -1, -1);
        gap(30);
        send_frame(4'b1101, 12'h456, 1'b1, BC, -1, -1);
        gap(30);

        // Reset during bit 8, then a full frame.
        send_frame(4'b1101, 12'h3C7, 1'b0, BC, -1, 8);
        gap(30);
        send_frame(4'b1101, 12'h3C7, 1'b0, BC, -1, -1);
        gap(30);

        // Bit-period drift in both directions.
        send_frame(4'b1101, 12'h5A5, 1'b0, 27, -1, -1);
        gap(30);
        send_frame(4'b1101, 12'h5A5, 1'b0, 23, -1, -1);
        gap(30);

        // Random payloads with occasional framing faults and random spacing.
        for (int k = 0; k < 10; k++) begin
            r_mode = int'($urandom_range(0, 3));
            r_hdr  = 4'b1101;
            r_tr   = 1'b0;
            if (r_mode == 0) r_hdr = r_hdr ^ 4'(1 << $urandom_range(0, 2));
            if (r_mode == 1) r_tr = 1'b1;
            send_frame(r_hdr, 12'($urandom), r_tr, BC, -1, -1);
            if (r_tr || ($urandom_range(0, 1) == 1)) gap(int'($urandom_range(2, 30)));
        end
        gap(50);

        for (int w = 0; w < 2000 && exp_q.size() > 0; w++) @(posedge clk);
        check("expectations_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/request_readin.md
Name: request_readin

Overview:
- Receive-side decoder for the 2-bit request line driven by the request writeout serializer. The link is a serial channel carrying one 12-bit request per frame.
- Recovers the request from the line, checks framing, and presents it as a one-cycle valid pulse.
- Sits at the input of the control FPGA/logic that consumes requests. The line may come from another clock domain, so the input is synchronized.

Parameters:
- BIT_CYCLES, 25, clock cycles per serial bit; must match the transmitter.
- DATA_W, 12, request payload width.
- HEADER, 4'b1101, fixed leading bits of every frame, MSB first.
- SYNC_STAGES, 2, synchronizer flops on UserInput (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- UserInput  in  2  serial line. 2'b01 = bit 1, 2'b10 = bit 0, 2'b00 and 2'b11 are illegal inside a frame.
- Request  out  DATA_W  last successfully decoded request; holds its value between frames.
- Request_vld  out  1  one-cycle pulse when Request has been updated.
- Frame_err  out  1  one-cycle pulse when a frame is aborted.
- Busy  out  1  high while a frame is being received.

Behaviour:
- Frame format, transmitted MSB first: HEADER (4 bits), payload (DATA_W bits, MSB first), trailer 1'b0. Default frame length is FRAME_LEN = 17 bits.
- Each symbol is held on the line for exactly BIT_CYCLES cycles. Consecutive equal bits produce no line transition.
- After a frame the line stays at its last symbol (normally 10); it never returns to 00.
- Reset:
  - Synchronizer flops and the previous-symbol register reset to 2'b01.
  - All outputs reset to 0; FSM resets to IDLE.
  - Consequence: a line already held at 01 when reset is released is not treated as a start. A non-01 symbol must be seen first.
- FSM states:
  - IDLE: Busy=0. A start is the synchronized symbol changing from any value to 01. On a start: bit counter = 0, cycle counter = 0, go to RX.
  - RX: Busy=1. The cycle counter increments every cycle and wraps to 0 at BIT_CYCLES-1, then the bit counter increments.
  - Resync in RX: any change of the synchronized symbol forces the cycle counter to 0.
- Sampling: when cycle counter == BIT_CYCLES/2 (12 by default), sample the symbol.
  - 01 shifts in 1; 10 shifts in 0.
  - 00 or 11: pulse Frame_err on the next cycle and return to IDLE. Request is unchanged.
- Frame check: on the sample of bit FRAME_LEN-1, evaluate the full shift register.
  - Pass condition: header == HEADER and trailer == 0.
  - On pass: Request <= payload and Request_vld = 1 on the next cycle.
  - On fail: Frame_err = 1 on the next cycle.
  - In both cases return to IDLE. No wait for the end of the trailer bit.
- Latency: Request_vld is high exactly SYNC_STAGES + (FRAME_LEN-1)*BIT_CYCLES + BIT_CYCLES/2 + 1 cycles after the first cycle UserInput shows 01. Default value: 415.
- Back-to-back frames: the line at 10 (from the trailer) followed by 01 is a valid start. This applies while in IDLE, including the cycle immediately after the decision.
- Request_vld and Frame_err are mutually exclusive and never assert while in IDLE without a preceding frame.
- Asserting reset mid-frame aborts immediately with no pulse. The next full frame decodes normally.

Decomposition:
- Package request_link_pkg holds:
  - SYM_ONE = 2'b01, SYM_ZERO = 2'b10.
  - HEADER_BITS = 4'b1101, HEADER_W = 4.
  - Function frame_len(DATA_W) = HEADER_W + DATA_W + 1.
  - FSM state enum {IDLE, RX}.
- Sub-module line_sync: SYNC_STAGES-deep 2-bit synchronizer with reset value 01. Outputs the synchronized symbol and a "changed" strobe.

Test Plan:
- Nominal: send frame for 0xA5C with transmitter timing (25 cycles per bit) -> Request = 0xA5C, single Request_vld pulse 415 cycles after first 01, Frame_err stays 0.
- Back-to-back: 0x000 then 0xFFF, the second starting right after the first trailer with the line at 10 between -> two Request_vld pulses, values 0x000 then 0xFFF. 0xFFF exercises 13 identical 01 bits with no transitions.
- Illegal symbol: drive 11 for 30 cycles during payload bit 5 -> Frame_err pulse 1 cycle after that bit's sample point, no Request_vld, Request keeps its previous value.
- Bad framing: header 1001 with payload 0x123 -> Frame_err and no vld. Correct header with trailer 1 -> Frame_err and no vld.
- Reset mid-frame: assert rst_n=0 during bit 8, release while the line is at 01 -> no pulses and no false start. The following complete frame 0x3C7 decodes correctly.
- Timing drift: stretch every bit to 27 cycles, then shrink to 23 -> 0x5A5 decoded correctly in both cases, due to resync on transitions.
